result_checker: RTL and testbench

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/result_checker_if.sv | 30 +++
 rtl/result_checker.sv | 183 ++++++++++++++++++
 tb/tb_result_checker.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_checker_if.sv
// Bus between the result checker and the harness that drives it.
// The harness side (master) drives the DUT result, the delayed operands and
// the measured latency; the checker side (slave) returns status and counters.
interface result_checker_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] i_dut_out;
    logic [WIDTH-1:0] i_delayed_a;
    logic [WIDTH-1:0] i_delayed_b;
    logic [WIDTH-1:0] i_dut_delay;

    logic [1:0]       o_state;
    logic [WIDTH-1:0] o_check_count;
    logic [WIDTH-1:0] o_error_count;
    logic             o_pass;
    logic [WIDTH-1:0] o_first_err_exp;
    logic [WIDTH-1:0] o_first_err_act;

    modport master (
        output i_dut_out, i_delayed_a, i_delayed_b, i_dut_delay,
        input  o_state, o_check_count, o_error_count, o_pass,
               o_first_err_exp, o_first_err_act
    );

    modport slave (
        input  i_dut_out, i_delayed_a, i_delayed_b, i_dut_delay,
        output o_state, o_check_count, o_error_count, o_pass,
               o_first_err_exp, o_first_err_act
    );
endinterface

// File: rtl/result_checker.sv
// Result checker for an adder DUT of unknown latency.
// Builds ref = a + b (carry dropped), delays it by the measured latency D and
// compares it against the DUT output, counting samples and mismatches.
// Optional macro FIRST_ERR_CAPTURE_EN: latch expected/actual of the first
// mismatch after reset; when undefined the first-error outputs are tied to 0.
module result_checker #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_DELAY = 15
) (
    input  logic              clk_dut,
    input  logic              reset_dut_n,
    result_checker_if.slave   chk_if
);

    localparam int unsigned FILL_W = $clog2(MAX_DELAY + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_CHECK = 2'b10,
        ST_UNSUP = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FILL_W-1:0]   r_fill;
    logic [FILL_W-1:0]   w_fill_nxt;
    logic [WIDTH-1:0]    r_d;
    logic [WIDTH-1:0]    w_d_nxt;
    logic [WIDTH-1:0]    r_check_cnt;
    logic [WIDTH-1:0]    r_error_cnt;
    logic                r_pass;
    logic [WIDTH-1:0]    w_check_nxt;
    logic [WIDTH-1:0]    w_error_nxt;
    logic                w_pass_nxt;
    logic                w_cmp;
    logic                w_mismatch;
    logic                w_dly_invalid;
    logic                w_d_changed;
    logic [WIDTH-1:0]    w_ref;
    logic [WIDTH-1:0]    w_tap;
    logic [WIDTH-1:0]    r_line [1:MAX_DELAY];

    assign w_ref         = chk_if.i_delayed_a + chk_if.i_delayed_b;
    assign w_dly_invalid = &chk_if.i_dut_delay;
    assign w_d_changed   = (chk_if.i_dut_delay != r_d);
    assign w_mismatch    = w_cmp && (chk_if.i_dut_out != w_tap);

    // Reference delay line: free-running, never reset; FILL covers its warm-up
    always_ff @(posedge clk_dut) begin
        r_line[1] <= w_ref;
        for (int unsigned k = 2; k <= MAX_DELAY; k++) begin
            r_line[k] <= r_line[k-1];
        end
    end

    // Tap select: D=0 uses the live sum, otherwise entry D holds ref(t-D)
    always_comb begin
        w_tap = w_ref;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
            if (r_d == WIDTH'(k)) begin
                w_tap = r_line[k];
            end
        end
    end

    // State, latched latency and fill counter registers
    always_ff @(posedge clk_dut or negedge reset_dut_n) begin
        if (!reset_dut_n) begin
            r_state <= ST_IDLE;
            r_fill  <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_d     <= w_d_nxt;
        end
    end

    // Next-state logic; an all-ones latency overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_d_nxt     = r_d;
        w_cmp       = 1'b0;
        if (w_dly_invalid) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (chk_if.i_dut_delay > WIDTH'(MAX_DELAY)) begin
                        w_state_nxt = ST_UNSUP;
                    end else begin
                        w_state_nxt = ST_FILL;
                        w_d_nxt     = chk_if.i_dut_delay;
                        w_fill_nxt  = FILL_W'(chk_if.i_dut_delay) + FILL_W'(1);
                    end
                end
                ST_FILL: begin
                    if (w_d_changed) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_fill_nxt = r_fill - FILL_W'(1);
                        if (r_fill == FILL_W'(1)) begin
                            w_state_nxt = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_d_changed) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cmp = 1'b1;
                    end
                end
                ST_UNSUP: begin
                    w_state_nxt = ST_UNSUP;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating counter updates and pass flag derived from next values
    always_comb begin
        w_check_nxt = r_check_cnt;
        w_error_nxt = r_error_cnt;
        if (w_cmp && (r_check_cnt != '1)) begin
            w_check_nxt = r_check_cnt + WIDTH'(1);
        end
        if (w_mismatch && (r_error_cnt != '1)) begin
            w_error_nxt = r_error_cnt + WIDTH'(1);
        end
        w_pass_nxt = (w_state_nxt == ST_CHECK) && (w_check_nxt != '0) &&
                     (w_error_nxt == '0);
    end

    // Counter and pass registers
    always_ff @(posedge clk_dut or negedge reset_dut_n) begin
        if (!reset_dut_n) begin
            r_check_cnt <= '0;
            r_error_cnt <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_check_cnt <= w_check_nxt;
            r_error_cnt <= w_error_nxt;
            r_pass      <= w_pass_nxt;
        end
    end

`ifdef FIRST_ERR_CAPTURE_EN
    logic             r_captured;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_act;

    // Latch the first mismatch after reset; later mismatches are ignored
    always_ff @(posedge clk_dut or negedge reset_dut_n) begin
        if (!reset_dut_n) begin
            r_captured  <= 1'b0;
            r_first_exp <= '0;
            r_first_act <= '0;
        end else if (w_mismatch && !r_captured) begin
            r_captured  <= 1'b1;
            r_first_exp <= w_tap;
            r_first_act <= chk_if.i_dut_out;
        end
    end

    assign chk_if.o_first_err_exp = r_first_exp;
    assign chk_if.o_first_err_act = r_first_act;
`else
    assign chk_if.o_first_err_exp = '0;
    assign chk_if.o_first_err_act = '0;
`endif

    assign chk_if.o_state       = r_state;
    assign chk_if.o_check_count = r_check_cnt;
    assign chk_if.o_error_count = r_error_cnt;
    assign chk_if.o_pass        = r_pass;

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker (WIDTH=32, MAX_DELAY=15).
// A cycle-indexed reference model tracks the expected outputs; directed
// scenarios add hand-computed literal expectations.
module tb_result_checker;

    localparam int unsigned W    = 32;
    localparam int unsigned MAXD = 15;
    localparam int          HN   = 8192;

    logic clk_dut;
    logic rst_n;

    result_checker_if #(.WIDTH(W)) bus ();

    result_checker #(.WIDTH(W), .MAX_DELAY(MAXD)) u_dut (
        .clk_dut     (clk_dut),
        .reset_dut_n (rst_n),
        .chk_if      (bus.slave)
    );

    initial clk_dut = 1'b0;
    always #5 clk_dut = ~clk_dut;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 fill, 2 check, 3 unsupported
    logic [W-1:0] hist [0:HN-1];
    int           cyc = 0;
    int           m_mode;
    logic [W-1:0] m_d;
    int           m_arm;
    logic [W-1:0] m_chk, m_err, m_fexp, m_fact;
    bit           m_cap;
    logic [W-1:0] m_dly, m_ref;

    always @(posedge clk_dut or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_d = '0; m_arm = 0;
            m_chk = '0; m_err = '0; m_fexp = '0; m_fact = '0; m_cap = 1'b0;
        end else begin
            m_dly = bus.i_dut_delay;
            hist[cyc % HN] = bus.i_delayed_a + bus.i_delayed_b;
            if (m_dly == '1) begin
                m_mode = 0;
            end else if (m_mode == 3) begin
                m_mode = 3;
            end else if (m_mode == 0) begin
                if (m_dly > W'(MAXD)) m_mode = 3;
                else begin m_mode = 1; m_d = m_dly; m_arm = cyc; end
            end else if (m_dly != m_d) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                if (cyc - m_arm == int'(m_d) + 1) m_mode = 2;
            end else begin
                m_ref = hist[(cyc - int'(m_d)) % HN];
                if (m_chk != '1) m_chk = m_chk + 1;
                if (bus.i_dut_out != m_ref) begin
                    if (m_err != '1) m_err = m_err + 1;
                    if (!m_cap) begin
                        m_cap = 1'b1;
`ifdef FIRST_ERR_CAPTURE_EN
                        m_fexp = m_ref;
                        m_fact = bus.i_dut_out;
`endif
                    end
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(posedge clk_dut) begin
        #1;
        if (cmp_en) begin
            chk("m_state", 32'(bus.o_state), 32'(m_mode));
            chk("m_check_count", bus.o_check_count, m_chk);
            chk("m_error_count", bus.o_error_count, m_err);
            chk("m_pass", 32'(bus.o_pass), 32'((m_mode == 2) && (m_chk != 0) && (m_err == 0)));
            chk("m_first_exp", bus.o_first_err_exp, m_fexp);
            chk("m_first_act", bus.o_first_err_act, m_fact);
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] outh [0:HN-1];
    int           n   = 0;
    int           lat = 0;

    // Drive one vector at negedge; ideal adder of latency lat, optional bit-0 flip
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input bit flip);
        logic [W-1:0] s;
        @(negedge clk_dut);
        bus.i_delayed_a = a;
        bus.i_delayed_b = b;
        s = a + b;
        outh[n % HN] = s ^ W'(flip);
        bus.i_dut_out = (n >= lat) ? outh[(n - lat) % HN] : '0;
        n++;
        @(posedge clk_dut);
        #1;
    endtask

    task automatic step_rand();
        step($urandom, $urandom, 1'b0);
    endtask

    // Step until CHECK is observed, counting FILL cycles; bounded
    task automatic run_to_check(input string name, input int exp_fill);
        int  fills;
        bit  ok;
        fills = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step_rand();
            if (bus.o_state == 2'b10) begin ok = 1'b1; break; end
            if (bus.o_state == 2'b01) fills++;
        end
        chk({name, "_reached_check"}, 32'(ok), 32'd1);
        chk({name, "_fill_len"}, 32'(fills), 32'(exp_fill));
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_state"}, 32'(bus.o_state), 32'd0);
        chk({name, "_chk"}, bus.o_check_count, 32'd0);
        chk({name, "_err"}, bus.o_error_count, 32'd0);
        chk({name, "_pass"}, 32'(bus.o_pass), 32'd0);
        chk({name, "_fexp"}, bus.o_first_err_exp, 32'd0);
        chk({name, "_fact"}, bus.o_first_err_act, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_dut_delay = '1;
        bus.i_delayed_a = '0;
        bus.i_delayed_b = '0;
        bus.i_dut_out   = '0;
        repeat (2) @(posedge clk_dut);
        #1;
        cmp_en = 1'b1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Unmeasured latency holds the checker idle
        lat = 3;
        repeat (100) step_rand();
        chk_zero_outputs("idle100");

        // D=3: four FILL cycles then 1000 compares including zero and carry vectors
        bus.i_dut_delay = 32'd3;
        run_to_check("d3", 4);
        for (int i = 0; i < 1000; i++) begin
            if (i == 10)      step(32'h0, 32'h0, 1'b0);
            else if (i == 20) step(32'hFFFF_FFFF, 32'h1, 1'b0);
            else              step_rand();
        end
        chk("d3_chk1000", bus.o_check_count, 32'd1000);
        chk("d3_err0", bus.o_error_count, 32'd0);
        chk("d3_pass", 32'(bus.o_pass), 32'd1);

        // Single corrupted result for 5+7
        step(32'd5, 32'd7, 1'b1);
        repeat (10) step_rand();
        chk("flip_err1", bus.o_error_count, 32'd1);
        chk("flip_chk", bus.o_check_count, 32'd1011);
        chk("flip_pass0", 32'(bus.o_pass), 32'd0);
`ifdef FIRST_ERR_CAPTURE_EN
        chk("flip_exp", bus.o_first_err_exp, 32'hC);
        chk("flip_act", bus.o_first_err_act, 32'hD);
`else
        chk("flip_exp", bus.o_first_err_exp, 32'h0);
        chk("flip_act", bus.o_first_err_act, 32'h0);
`endif

        // Latency change mid-CHECK: back to IDLE, counts kept, then 5 FILL cycles
        bus.i_dut_delay = 32'd4;
        lat = 4;
        step_rand();
        chk("dchg_state", 32'(bus.o_state), 32'd0);
        chk("dchg_chk", bus.o_check_count, 32'd1011);
        chk("dchg_err", bus.o_error_count, 32'd1);
        run_to_check("d4", 5);
        repeat (20) step_rand();
        chk("d4_chk", bus.o_check_count, 32'd1031);

        // Asynchronous reset mid-CHECK clears everything without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        repeat (2) step_rand();
        rst_n = 1'b1;
        run_to_check("postrst", 5);
        repeat (20) step_rand();
        chk("postrst_chk", bus.o_check_count, 32'd20);
        chk("postrst_pass", 32'(bus.o_pass), 32'd1);

        // D=0 compares against the live sum
        bus.i_dut_delay = 32'd0;
        lat = 0;
        step_rand();
        run_to_check("d0", 1);
        repeat (10) step_rand();
        chk("d0_err", bus.o_error_count, 32'd0);

        // Largest supported latency
        bus.i_dut_delay = 32'd15;
        lat = 15;
        step_rand();
        run_to_check("d15", 16);
        repeat (30) step_rand();
        chk("d15_err", bus.o_error_count, 32'd0);

        // Unsupported latency is sticky until the latency goes back to all-ones
        bus.i_dut_delay = 32'd16;
        step_rand();
        step_rand();
        chk("unsup_state", 32'(bus.o_state), 32'd3);
        bus.i_dut_delay = 32'd3;
        repeat (3) step_rand();
        chk("unsup_sticky", 32'(bus.o_state), 32'd3);
        bus.i_dut_delay = '1;
        step_rand();
        chk("unsup_exit", 32'(bus.o_state), 32'd0);
        repeat (3) step_rand();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
